// File: rtl/fll_pkg.sv
// fll_pkg: shared widths, lane index type and lane placement for the FLL width packer
package fll_pkg;
  typedef logic [15:0] lane_t;
  function automatic int cnt_w(int n);
    return $clog2(n + 1);
  endfunction
  function automatic int lane_pos(lane_t l, int n, int iw, bit be);
    return (be ? n - 1 - int'(l) : int'(l)) * iw;
  endfunction
endpackage

// File: rtl/fll_pkr_tmo.sv
// fll_pkr_tmo: idle counter that requests a flush of a partial word after TO idle cycles
module fll_pkr_tmo #(
  parameter int TO = 16
) (
  input  logic pki_clk,
  input  logic pki_rst_n,
  input  logic arm,
  input  logic clear,
  input  logic free,
  output logic flush
);
  localparam int TW = $clog2(TO + 1);
  logic [TW-1:0] cnt;
  assign flush = arm & free & (cnt == TW'(TO));
  // count idle cycles while a partial word waits; saturate at TO until the output frees up
  always_ff @(posedge pki_clk)
    if (!pki_rst_n || clear || flush) cnt <= '0;
    else if (arm && cnt != TW'(TO)) cnt <= cnt + TW'(1);
endmodule

// File: rtl/fll_pkr.sv
// fll_pkr: packs N narrow words into one wide registered word; idle flush under FLL_PKR_TMO_EN
module fll_pkr import fll_pkg::*; #(
  parameter int IW = 8,
  parameter int N  = 4,
  parameter bit BE = 1'b0,
  parameter int TO = 16
) (
  input  logic                  pki_clk,
  input  logic                  pki_rst_n,
  input  logic [IW-1:0]         pki_bus,
  input  logic                  pki_lst,
  input  logic                  pki_vld,
  output logic                  pki_rdy,
  output logic [N*IW-1:0]       pko_bus,
  output logic [cnt_w(N)-1:0]   pko_cnt,
  output logic                  pko_lst,
  output logic                  pko_vld,
  input  logic                  pko_rdy
);
  localparam int LW = N > 1 ? $clog2(N) : 1;
  localparam int CW = cnt_w(N);
  logic [N*IW-1:0] acc, mrg;
  logic [LW-1:0] lane;
  logic [CW-1:0] lc;
  logic xin, done, fl;
  assign pki_rdy = !pko_vld | pko_rdy;
  assign xin = pki_vld & pki_rdy;
  assign done = xin & (lane == LW'(N - 1) | pki_lst);
  assign lc = CW'(lane);
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam int P = lane_pos(lane_t'(g), N, IW, BE);
    assign mrg[P +: IW] = lane == LW'(g) ? pki_bus : acc[P +: IW];
  end
`ifdef FLL_PKR_TMO_EN
  fll_pkr_tmo #(.TO(TO)) u_tmo (
    .pki_clk  (pki_clk),
    .pki_rst_n(pki_rst_n),
    .arm      (lane != '0 && !xin),
    .clear    (xin),
    .free     (pki_rdy),
    .flush    (fl)
  );
`else
  assign fl = 1'b0;
`endif
  // output register: completion wins, then flush, otherwise drop valid once taken
  always_ff @(posedge pki_clk)
    if (!pki_rst_n) begin
      pko_bus <= '0;
      pko_cnt <= '0;
      pko_lst <= 1'b0;
      pko_vld <= 1'b0;
    end else if (done) begin
      pko_bus <= mrg;
      pko_cnt <= lc + CW'(1);
      pko_lst <= pki_lst;
      pko_vld <= 1'b1;
    end else if (fl) begin
      pko_bus <= acc;
      pko_cnt <= lc;
      pko_lst <= 1'b0;
      pko_vld <= 1'b1;
    end else if (pko_rdy) pko_vld <= 1'b0;
  // accumulator and lane pointer; cleared whenever a word leaves for the output register
  always_ff @(posedge pki_clk)
    if (!pki_rst_n || done || fl) begin
      acc  <= '0;
      lane <= '0;
    end else if (xin) begin
      acc  <= mrg;
      lane <= lane + LW'(1);
    end
endmodule
